// File: rtl/oam_dma_arbiter_pkg.sv
// Shared constants and FSM encoding for the OAM DMA bus arbiter.
// Included by the arbiter and anything that decodes its state.
package oam_dma_arbiter_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;

    localparam logic [15:0] DMA_PAGE_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR  = 16'h2004;

    typedef enum logic [2:0] {
        DMA_IDLE      = 3'd0,
        DMA_HALT_WAIT = 3'd1,
        DMA_HALT      = 3'd2,
        DMA_ALIGN     = 3'd3,
        DMA_READ      = 3'd4,
        DMA_WRITE     = 3'd5
    } dma_state_e;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU bus between the CPU and the OAM DMA engine; a write of page P
// to the DMA page register stalls the CPU and copies P00..PFF into OAMDATA.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = oam_dma_arbiter_pkg::ADDR_WIDTH,
    parameter int                    REG_WIDTH     = oam_dma_arbiter_pkg::REG_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] DMA_PAGE_ADDR = ADDR_WIDTH'(oam_dma_arbiter_pkg::DMA_PAGE_ADDR),
    parameter logic [ADDR_WIDTH-1:0] OAMDATA_ADDR  = ADDR_WIDTH'(oam_dma_arbiter_pkg::OAMDATA_ADDR)
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_rw,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_wdata,
    output logic                  cpu_rdy,
    output logic [REG_WIDTH-1:0]  cpu_rdata,
    output logic                  mem_en,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic                  dma_active
);

    dma_state_e           state, state_nxt;
    logic [7:0]           page, page_nxt;
    logic [7:0]           idx, idx_nxt;
    logic [REG_WIDTH-1:0] data_buf, data_buf_nxt;
    logic                 par;

    logic                  cpu_wr;
    logic                  trig;
    logic                  cpu_own;
    logic                  dma_en;
    logic                  dma_rw;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [REG_WIDTH-1:0]  dma_wdata;

    assign cpu_wr = cpu_req & ~cpu_rw;
    assign trig   = cpu_wr && (cpu_addr == DMA_PAGE_ADDR);

    always_ff @(posedge phi1) begin
        if (reset) begin
            state    <= DMA_IDLE;
            page     <= '0;
            idx      <= '0;
            data_buf <= '0;
            par      <= 1'b0;
        end else begin
            state    <= state_nxt;
            page     <= page_nxt;
            idx      <= idx_nxt;
            data_buf <= data_buf_nxt;
            par      <= ~par;
        end
    end

    always_comb begin
        state_nxt    = state;
        page_nxt     = page;
        idx_nxt      = idx;
        data_buf_nxt = data_buf;
        cpu_rdy      = 1'b0;
        dma_active   = 1'b1;
        cpu_own      = 1'b0;
        dma_en       = 1'b0;
        dma_rw       = 1'b1;
        dma_addr     = '0;
        dma_wdata    = '0;
        case (state)
            DMA_IDLE: begin
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                cpu_own    = 1'b1;
                if (trig) begin
                    page_nxt  = 8'(cpu_wdata);
                    idx_nxt   = '0;
                    state_nxt = DMA_HALT_WAIT;
                end
            end
            DMA_HALT_WAIT: begin
                // RDY cannot stall a 6502 write, so pending writes keep the bus
                if (cpu_wr) begin
                    cpu_own = 1'b1;
                    if (trig) page_nxt = 8'(cpu_wdata);
                end else begin
                    state_nxt = DMA_HALT;
                end
            end
            DMA_HALT:  state_nxt = par ? DMA_ALIGN : DMA_READ;
            DMA_ALIGN: state_nxt = DMA_READ;
            DMA_READ: begin
                dma_en       = 1'b1;
                dma_addr     = ADDR_WIDTH'({page, idx});
                data_buf_nxt = mem_rdata;
                state_nxt    = DMA_WRITE;
            end
            DMA_WRITE: begin
                dma_en    = 1'b1;
                dma_rw    = 1'b0;
                dma_addr  = OAMDATA_ADDR;
                dma_wdata = data_buf;
                idx_nxt   = idx + 8'd1;
                state_nxt = (idx == 8'hFF) ? DMA_IDLE : DMA_READ;
            end
            default: state_nxt = DMA_IDLE;
        endcase
    end

    // Reset kills an in-flight DMA cycle at once rather than on the next edge
    assign mem_en    = cpu_own ? cpu_req   : (dma_en & ~reset);
    assign mem_rw    = cpu_own ? cpu_rw    : dma_rw;
    assign mem_addr  = cpu_own ? cpu_addr  : dma_addr;
    assign mem_wdata = cpu_own ? cpu_wdata : dma_wdata;
    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: a scoreboard of expected bus cycles is
// filled as stimulus is driven and drained by a bus monitor on the falling edge.
module tb_oam_dma_arbiter;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;

    logic        phi1;
    logic        reset;
    logic        cpu_req;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    int   checks = 0;
    int   errors = 0;
    int   rdy_low = 0;
    bus_t exp_q[$];
    bus_t e;
    logic p;
    logic [15:0] last_rd_addr;
    logic [7:0]  last_wr_data;
    logic        saw_zero;

    oam_dma_arbiter dut (
        .phi1(phi1), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dma_active(dma_active)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    function automatic logic [7:0] memf(input logic [15:0] a);
        case (a)
            16'hFFFF: return 8'hA5;
            16'h4014: return 8'h33;
            default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    always_comb mem_rdata = memf(mem_addr);

    // Reference model of the free-running parity bit
    always @(posedge phi1) p <= reset ? 1'b0 : ~p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge phi1) begin
        if (reset) begin
            chk("reset_no_oam_write", {31'd0, mem_en & ~mem_rw & (mem_addr == 16'h2004)}, 32'd0);
        end else begin
            if (!cpu_rdy) rdy_low++;
            if (mem_en) begin
                if (mem_addr == 16'h0000) saw_zero = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("bus_unexpected", {31'd0, mem_en}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_rw", {31'd0, mem_rw}, {31'd0, e.rw});
                    chk("bus_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    if (e.rw) begin
                        chk("bus_rdata", {24'd0, cpu_rdata}, {24'd0, e.data});
                        last_rd_addr = mem_addr;
                    end else begin
                        chk("bus_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
                        last_wr_data = mem_wdata;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_wdata = d;
        exp_q.push_back('{rw: 1'b0, addr: a, data: d});
        step();
    endtask

    task automatic hold_read();
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h00;
    endtask

    task automatic push_dma(input logic [7:0] pg);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {pg, 8'(i)};
            exp_q.push_back('{rw: 1'b1, addr: a, data: memf(a)});
            exp_q.push_back('{rw: 1'b0, addr: 16'h2004, data: memf(a)});
        end
    endtask

    task automatic sync_par(input logic want);
        cpu_req = 1'b0;
        while (p != want) step();
    endtask

    // HALT_WAIT clocks + HALT + optional ALIGN + 256 read/write pairs
    function automatic int exp_low(input int hw, input logic pt);
        logic halt_par;
        halt_par = pt ^ logic'(hw[0]) ^ 1'b1;
        return hw + 1 + int'(halt_par) + 512;
    endfunction

    task automatic wait_dma(input string tag, input int expected_low);
        int n;
        hold_read();
        n = 0;
        while (dma_active && n < 700) begin
            step();
            n++;
        end
        cpu_req = 1'b0;
        chk({tag, "_done"}, {31'd0, dma_active}, 32'd0);
        chk({tag, "_rdy_low"}, rdy_low, expected_low);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pt;
        int n;
        reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        saw_zero = 1'b0; last_rd_addr = '0; last_wr_data = '0;
        step();
        cpu_req = 1'b1; cpu_addr = 16'h1234;
        #1;
        chk("reset_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("reset_active", {31'd0, dma_active}, 32'd0);
        chk("reset_bus_follow_en", {31'd0, mem_en}, 32'd1);
        chk("reset_bus_follow_addr", {16'd0, mem_addr}, 32'h1234);
        cpu_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Plain read of the trigger address
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h4014;
        exp_q.push_back('{rw: 1'b1, addr: 16'h4014, data: 8'h33});
        #1;
        chk("rd4014_rdata", {24'd0, cpu_rdata}, 32'h33);
        chk("rd4014_rdy", {31'd0, cpu_rdy}, 32'd1);
        step();
        cpu_req = 1'b0;
        chk("rd4014_no_trigger", {31'd0, dma_active}, 32'd0);
        chk("rd4014_rdy_after", {31'd0, cpu_rdy}, 32'd1);

        // Even parity at HALT
        sync_par(1'b0);
        rdy_low = 0; pt = p;
        cpu_wr(16'h4014, 8'h02);
        chk("t2_active", {31'd0, dma_active}, 32'd1);
        chk("t2_rdy_low", {31'd0, cpu_rdy}, 32'd0);
        push_dma(8'h02);
        wait_dma("t2", exp_low(1, pt));

        // Odd parity at HALT inserts the ALIGN cycle
        sync_par(1'b1);
        rdy_low = 0; pt = p;
        cpu_wr(16'h4014, 8'h02);
        push_dma(8'h02);
        wait_dma("t3", exp_low(1, pt));

        // Trigger in the middle of three back-to-back writes
        step();
        rdy_low = 0;
        cpu_wr(16'h0100, 8'hAA);
        pt = p;
        cpu_wr(16'h4014, 8'h03);
        cpu_wr(16'h01FF, 8'hBB);
        push_dma(8'h03);
        wait_dma("t4", exp_low(2, pt));

        // Top page, source addresses stay within FF00..FFFF
        step();
        rdy_low = 0; saw_zero = 1'b0; pt = p;
        cpu_wr(16'h4014, 8'hFF);
        push_dma(8'hFF);
        wait_dma("t5", exp_low(1, pt));
        chk("t5_last_rd_addr", {16'd0, last_rd_addr}, 32'hFFFF);
        chk("t5_last_wr_data", {24'd0, last_wr_data}, 32'hA5);
        chk("t5_no_0000", {31'd0, saw_zero}, 32'd0);

        // Reset while idx is 0x40
        step();
        cpu_wr(16'h4014, 8'h01);
        push_dma(8'h01);
        hold_read();
        n = 0;
        while (exp_q.size() > 512 - 8'h80 && n < 400) begin
            step();
            n++;
        end
        chk("t1_reached_idx40", exp_q.size(), 512 - 8'h80);
        cpu_req = 1'b0;
        reset = 1'b1;
        step();
        step();
        step();
        exp_q.delete();
        reset = 1'b0;
        chk("t1_rdy_after_reset", {31'd0, cpu_rdy}, 32'd1);
        chk("t1_active_after_reset", {31'd0, dma_active}, 32'd0);
        step();
        chk("t1_rdy_next", {31'd0, cpu_rdy}, 32'd1);
        chk("t1_active_next", {31'd0, dma_active}, 32'd0);

        // A fresh DMA after the abort starts again from idx 0
        rdy_low = 0; pt = p;
        cpu_wr(16'h4014, 8'h10);
        push_dma(8'h10);
        wait_dma("t7", exp_low(1, pt));

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
